// File: rtl/al_accel_pkg.sv
// COMPS sequencer shared types: layer-type codes and FSM state encoding.
// Imported by the sequencer top and its interface users.
package al_accel_pkg;

  localparam logic [3:0] LT_CONV  = 4'd0;
  localparam logic [3:0] LT_DENSE = 4'd1;
  localparam logic [3:0] LT_POOL  = 4'd2;

  typedef enum logic [2:0] {
    S_START,
    S_MAC,
    S_ACC,
    S_POOL,
    S_WAIT,
    S_FIN,
    S_ERR
  } state_e;

  function automatic logic lt_legal(input logic [3:0] lt);
    return (lt == LT_CONV) || (lt == LT_DENSE) || (lt == LT_POOL);
  endfunction

endpackage

// File: rtl/al_accel_comps_seq_if.sv
// RDATA -> COMPS -> WBACK handshake and side-band bundle.
// master: sequencer side (takes rdata_*/wback_*, drives comps_*); slave: peer side.
interface al_accel_comps_seq_if #(
  parameter int ADDR_W = 32,
  parameter int QSEL_W = 4
);
  logic              rdata_rdy;
  logic              rdata_fin;
  logic              rdata_is_out_fin;
  logic [ADDR_W-1:0] rdata_ps_addr;
  logic [ADDR_W-1:0] rdata_o_addr;
  logic [QSEL_W-1:0] rdata_o_quant_sel;
  logic              wback_rdy;
  logic              wback_start;
  logic              comps_start;
  logic              comps_rdy;
  logic              comps_fin;
  logic              comps_is_out_fin;
  logic [ADDR_W-1:0] comps_ps_addr;
  logic [ADDR_W-1:0] comps_o_addr;
  logic [QSEL_W-1:0] comps_o_quant_sel;

  modport master (
    input  rdata_rdy, rdata_fin, rdata_is_out_fin,
    input  rdata_ps_addr, rdata_o_addr, rdata_o_quant_sel,
    input  wback_rdy, wback_start,
    output comps_start, comps_rdy, comps_fin,
    output comps_is_out_fin, comps_ps_addr,
    output comps_o_addr, comps_o_quant_sel
  );

  modport slave (
    output rdata_rdy, rdata_fin, rdata_is_out_fin,
    output rdata_ps_addr, rdata_o_addr, rdata_o_quant_sel,
    output wback_rdy, wback_start,
    input  comps_start, comps_rdy, comps_fin,
    input  comps_is_out_fin, comps_ps_addr,
    input  comps_o_addr, comps_o_quant_sel
  );
endinterface

// File: rtl/al_accel_comps_sideband.sv
// Side-band capture register: loads once per tile on load=1.
// Ports: clk/resetn, load, d_* capture inputs, q_* registered outputs.
module al_accel_comps_sideband #(
  parameter int ADDR_W = 32,
  parameter int QSEL_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              d_is_out_fin,
  input  logic [ADDR_W-1:0] d_ps_addr,
  input  logic [ADDR_W-1:0] d_o_addr,
  input  logic [QSEL_W-1:0] d_qsel,
  output logic              q_is_out_fin,
  output logic [ADDR_W-1:0] q_ps_addr,
  output logic [ADDR_W-1:0] q_o_addr,
  output logic [QSEL_W-1:0] q_qsel
);
  logic              iof_q, iof_d;
  logic [ADDR_W-1:0] ps_q, ps_d;
  logic [ADDR_W-1:0] oa_q, oa_d;
  logic [QSEL_W-1:0] qs_q, qs_d;

  always_comb begin
    iof_d = iof_q;
    ps_d  = ps_q;
    oa_d  = oa_q;
    qs_d  = qs_q;
    if (load) begin
      iof_d = d_is_out_fin;
      ps_d  = d_ps_addr;
      oa_d  = d_o_addr;
      qs_d  = d_qsel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iof_q <= 1'b0;
      ps_q  <= '0;
      oa_q  <= '0;
      qs_q  <= '0;
    end else begin
      iof_q <= iof_d;
      ps_q  <= ps_d;
      oa_q  <= oa_d;
      qs_q  <= qs_d;
    end
  end

  assign q_is_out_fin = iof_q;
  assign q_ps_addr    = ps_q;
  assign q_o_addr     = oa_q;
  assign q_qsel       = qs_q;
endmodule

// File: rtl/al_accel_comps_seq.sv
// COMPS stage sequencer: drives PU/accumulate/pool matrices per tile, forwards side-band.
// Ports: clk, resetn, enb, cfg_*, pu_matrix_rdy, bus (master), matrix enables, cfg_err.
// COMPS_PERF_CNT_EN adds perf_busy_cnt / perf_stall_cnt.
module al_accel_comps_seq
  import al_accel_pkg::*;
#(
  parameter int N_PU    = 9,
  parameter int ADDR_W  = 32,
  parameter int QSEL_W  = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enb,
  input  logic [3:0]         cfg_layer_typ,
  input  logic [N_PU-1:0]    cfg_dense_mask,
  input  logic [DWELL_W-1:0] cfg_mac_dwell,
  input  logic               pu_matrix_rdy,
  al_accel_comps_seq_if.master bus,
  output logic [N_PU-1:0]    pu_enb,
  output logic               acc_enb,
  output logic               acc_bps_write,
  output logic               acc_inter_sum_write,
  output logic               pool_enb,
  output logic               comps_cfg_err
`ifdef COMPS_PERF_CNT_EN
  ,
  output logic [31:0]        perf_busy_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  state_e             state_q, state_d;
  logic [3:0]         layer_q, layer_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_init;
  logic               first_q, first_d;
  logic               err_q, err_d;
  logic               go, takeoff, cap;
  logic [3:0]         lt;

  assign go = (bus.rdata_rdy | bus.rdata_fin) & enb;

  // Dwell of 0 behaves as 1: counter starts at max(dwell,1)-1.
  assign dwell_init = (cfg_mac_dwell == '0) ? '0
                    : cfg_mac_dwell - 1'b1;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    err_d   = err_q;
    takeoff = 1'b0;
    cap     = 1'b0;
    lt      = layer_q;
    if (enb) begin
      case (state_q)
        S_START: begin
          takeoff = go & bus.wback_start;
          lt      = cfg_layer_typ;
          if (takeoff) layer_d = cfg_layer_typ;
        end
        S_WAIT: begin
          takeoff = go & (bus.wback_rdy | bus.wback_start);
        end
        S_MAC: begin
          first_d = 1'b0;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else if (pu_matrix_rdy) state_d = S_ACC;
        end
        S_ACC, S_POOL: state_d = S_WAIT;
        default: ;
      endcase
    end
    if (takeoff) begin
      if (!lt_legal(lt)) begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end else if (bus.rdata_fin) begin
        state_d = S_FIN;
      end else begin
        cap = 1'b1;
        if (lt == LT_POOL) begin
          state_d = S_POOL;
        end else begin
          state_d = S_MAC;
          cnt_d   = dwell_init;
          first_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_START;
      layer_q <= LT_CONV;
      cnt_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pu_enb              = '0;
    acc_enb             = 1'b0;
    acc_bps_write       = 1'b0;
    acc_inter_sum_write = 1'b0;
    pool_enb            = 1'b0;
    unique case (1'b1)
      state_q == S_MAC: begin
        pu_enb        = (layer_q == LT_DENSE) ? cfg_dense_mask
                      : {N_PU{1'b1}};
        acc_enb       = first_q;
        acc_bps_write = first_q;
      end
      state_q == S_ACC: begin
        acc_enb             = 1'b1;
        acc_inter_sum_write = 1'b1;
      end
      state_q == S_POOL: pool_enb = 1'b1;
      default: ;
    endcase
  end

  assign comps_cfg_err   = err_q;
  assign bus.comps_start = (state_q == S_START);
  assign bus.comps_rdy   = (state_q == S_WAIT);
  assign bus.comps_fin   = (state_q == S_FIN);

  al_accel_comps_sideband #(
    .ADDR_W(ADDR_W),
    .QSEL_W(QSEL_W)
  ) u_sb (
    .clk          (clk),
    .resetn       (resetn),
    .load         (cap),
    .d_is_out_fin (bus.rdata_is_out_fin),
    .d_ps_addr    (bus.rdata_ps_addr),
    .d_o_addr     (bus.rdata_o_addr),
    .d_qsel       (bus.rdata_o_quant_sel),
    .q_is_out_fin (bus.comps_is_out_fin),
    .q_ps_addr    (bus.comps_ps_addr),
    .q_o_addr     (bus.comps_o_addr),
    .q_qsel       (bus.comps_o_quant_sel)
  );

`ifdef COMPS_PERF_CNT_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (enb) begin
      if ((state_q inside {S_MAC, S_ACC, S_POOL}) && (busy_q != '1))
        busy_d = busy_q + 32'd1;
      if ((state_q == S_WAIT) && !takeoff && (stall_q != '1))
        stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cnt  = busy_q;
  assign perf_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_al_accel_comps_seq.sv
// Self-checking bench for al_accel_comps_seq.
// Randomized tiles checked against a per-tile expected-trace model.
module tb_al_accel_comps_seq;
  localparam logic [3:0] CONV  = 4'd0;
  localparam logic [3:0] DENSE = 4'd1;
  localparam logic [3:0] POOL  = 4'd2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enb;
  logic [3:0] cfg_layer_typ;
  logic [8:0] cfg_dense_mask;
  logic [3:0] cfg_mac_dwell;
  logic       pu_matrix_rdy;
  logic [8:0] pu_enb;
  logic       acc_enb, acc_bps_write, acc_inter_sum_write;
  logic       pool_enb, comps_cfg_err;
`ifdef COMPS_PERF_CNT_EN
  logic [31:0] perf_busy_cnt, perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  al_accel_comps_seq_if #(.ADDR_W(32), .QSEL_W(4)) bus ();

  always #5 clk = ~clk;

  al_accel_comps_seq dut (
    .clk                 (clk),
    .resetn              (resetn),
    .enb                 (enb),
    .cfg_layer_typ       (cfg_layer_typ),
    .cfg_dense_mask      (cfg_dense_mask),
    .cfg_mac_dwell       (cfg_mac_dwell),
    .pu_matrix_rdy       (pu_matrix_rdy),
    .bus                 (bus),
    .pu_enb              (pu_enb),
    .acc_enb             (acc_enb),
    .acc_bps_write       (acc_bps_write),
    .acc_inter_sum_write (acc_inter_sum_write),
    .pool_enb            (pool_enb),
    .comps_cfg_err       (comps_cfg_err)
`ifdef COMPS_PERF_CNT_EN
    ,
    .perf_busy_cnt       (perf_busy_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    bus.rdata_rdy         = 1'b0;
    bus.rdata_fin         = 1'b0;
    bus.wback_rdy         = 1'b0;
    bus.wback_start       = 1'b0;
  endtask

  task automatic scramble_sb();
    bus.rdata_is_out_fin  = 1'($urandom);
    bus.rdata_ps_addr     = $urandom;
    bus.rdata_o_addr      = $urandom;
    bus.rdata_o_quant_sel = 4'($urandom);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enb = 1'b1;
    cfg_layer_typ = CONV;
    cfg_dense_mask = '0;
    cfg_mac_dwell = '0;
    pu_matrix_rdy = 1'b0;
    clr_bus();
    scramble_sb();
    step();
    step();
    resetn = 1'b1;
  endtask

  // One tile: the trace follows from the rules alone --
  // MAC lasts max(max(dwell,1), rdly+1) cycles, then one ACC, then WAIT;
  // POOL is one strobe cycle, then WAIT.
  task automatic run_tile(input logic [3:0] lt, input int dwell,
                          input int rdly, input bit from_start,
                          input int id);
    logic [31:0] ps, oa;
    logic [3:0]  qs;
    logic        iof;
    logic [8:0]  exp_pu;
    int          nmac;
    ps  = $urandom;
    oa  = $urandom;
    qs  = 4'($urandom);
    iof = 1'($urandom);
    bus.rdata_ps_addr     = ps;
    bus.rdata_o_addr      = oa;
    bus.rdata_o_quant_sel = qs;
    bus.rdata_is_out_fin  = iof;
    cfg_mac_dwell = 4'(dwell);
    pu_matrix_rdy = 1'b0;
    bus.rdata_rdy = 1'b1;
    if (from_start || ($urandom_range(0, 1) == 0))
      bus.wback_start = 1'b1;
    else
      bus.wback_rdy = 1'b1;
    step();
    clr_bus();
    scramble_sb();
    cfg_layer_typ = 4'($urandom);
    cfg_mac_dwell = 4'($urandom);
    exp_pu = (lt == DENSE) ? cfg_dense_mask : 9'h1FF;
    if (lt == POOL) begin
      chk($sformatf("t%0d pool", id), 64'(pool_enb), 1);
      chk($sformatf("t%0d pool_pu", id), 64'(pu_enb), 0);
      step();
      chk($sformatf("t%0d pool_once", id), 64'(pool_enb), 0);
    end else begin
      nmac = (dwell < 1) ? 1 : dwell;
      if (rdly + 1 > nmac) nmac = rdly + 1;
      for (int i = 0; i < nmac; i++) begin
        pu_matrix_rdy = (i >= rdly);
        chk($sformatf("t%0d mac%0d pu", id, i), 64'(pu_enb), 64'(exp_pu));
        chk($sformatf("t%0d mac%0d bps", id, i),
            64'(acc_bps_write), 64'(i == 0));
        chk($sformatf("t%0d mac%0d acc", id, i),
            64'(acc_enb), 64'(i == 0));
        step();
      end
      pu_matrix_rdy = 1'b0;
      chk($sformatf("t%0d acc_isw", id), 64'(acc_inter_sum_write), 1);
      chk($sformatf("t%0d acc_en", id), 64'(acc_enb), 1);
      chk($sformatf("t%0d acc_pu", id), 64'(pu_enb), 0);
      step();
    end
    chk($sformatf("t%0d rdy", id), 64'(bus.comps_rdy), 1);
    chk($sformatf("t%0d ps", id), 64'(bus.comps_ps_addr), 64'(ps));
    chk($sformatf("t%0d oa", id), 64'(bus.comps_o_addr), 64'(oa));
    chk($sformatf("t%0d qs", id), 64'(bus.comps_o_quant_sel), 64'(qs));
    chk($sformatf("t%0d iof", id), 64'(bus.comps_is_out_fin), 64'(iof));
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wback_rdy   = 1'($urandom);
      bus.wback_start = 1'($urandom);
      step();
      chk("stall_rdy", 64'(bus.comps_rdy), 1);
      chk("stall_pu", 64'(pu_enb), 0);
    end
    clr_bus();
  endtask

  task automatic finish_stream();
    bus.rdata_fin = 1'b1;
    bus.rdata_rdy = 1'($urandom);
    bus.wback_rdy = 1'b1;
    step();
    clr_bus();
    chk("fin", 64'(bus.comps_fin), 1);
    chk("fin_rdy", 64'(bus.comps_rdy), 0);
    bus.rdata_rdy = 1'b1;
    bus.wback_start = 1'b1;
    step();
    clr_bus();
    chk("fin_hold", 64'(bus.comps_fin), 1);
    chk("fin_pool", 64'(pool_enb), 0);
  endtask

  task automatic rand_session(input logic [3:0] lt, input int ntile);
    do_reset();
    cfg_dense_mask = 9'($urandom_range(1, 511));
    cfg_layer_typ = lt;
    for (int t = 0; t < ntile; t++) begin
      if (t > 0) stall($urandom_range(0, 3));
      run_tile(lt, $urandom_range(0, 5), $urandom_range(0, 6),
               t == 0, t);
    end
    finish_stream();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int mac_cycles;

    do_reset();
    chk("rst_start", 64'(bus.comps_start), 1);
    chk("rst_pu", 64'(pu_enb), 0);
    chk("rst_acc", 64'(acc_enb), 0);
    chk("rst_pool", 64'(pool_enb), 0);
    chk("rst_err", 64'(comps_cfg_err), 0);
    chk("rst_oa", 64'(bus.comps_o_addr), 0);
    chk("rst_ps", 64'(bus.comps_ps_addr), 0);

    // CONV: directed dwell=3 with rdy tied, then random tiles
    cfg_layer_typ = CONV;
    cfg_dense_mask = 9'($urandom);
    run_tile(CONV, 3, 0, 1'b1, 0);
    stall(2);
    run_tile(CONV, $urandom_range(0, 5), $urandom_range(0, 6), 1'b0, 1);
    finish_stream();

    // DENSE: mask 0x007, dwell 0, rdy late by 4
    do_reset();
    cfg_dense_mask = 9'h007;
    cfg_layer_typ = DENSE;
    run_tile(DENSE, 0, 4, 1'b1, 0);
    run_tile(DENSE, $urandom_range(0, 5), $urandom_range(0, 6), 1'b0, 1);
    finish_stream();

    rand_session(DENSE, 4);
    rand_session(POOL, 3);
    rand_session(CONV, 5);

    // illegal layer type
    do_reset();
    cfg_layer_typ = 4'd7;
    bus.rdata_rdy = 1'b1;
    bus.wback_start = 1'b1;
    step();
    clr_bus();
    chk("err_set", 64'(comps_cfg_err), 1);
    chk("err_start", 64'(bus.comps_start), 0);
    for (int i = 0; i < 4; i++) begin
      cfg_layer_typ = 4'($urandom_range(0, 2));
      bus.rdata_rdy = 1'($urandom);
      bus.wback_start = 1'($urandom);
      bus.wback_rdy = 1'($urandom);
      step();
      chk("err_hold", 64'(comps_cfg_err), 1);
      chk("err_pu", 64'(pu_enb), 0);
      chk("err_pool", 64'(pool_enb), 0);
      chk("err_rdy", 64'(bus.comps_rdy), 0);
    end
    clr_bus();

    // async reset mid-MAC
    do_reset();
    cfg_layer_typ = CONV;
    cfg_mac_dwell = 4'd5;
    bus.rdata_o_addr = 32'h100;
    bus.rdata_rdy = 1'b1;
    bus.wback_start = 1'b1;
    step();
    clr_bus();
    step();
    chk("mid_pu_pre", 64'(pu_enb), 64'h1FF);
    #2 resetn = 1'b0;
    #1;
    chk("arst_pu", 64'(pu_enb), 0);
    chk("arst_acc", 64'(acc_enb), 0);
    chk("arst_oa", 64'(bus.comps_o_addr), 0);
    step();
    resetn = 1'b1;
    step();
    chk("arst_start", 64'(bus.comps_start), 1);

    // enb freeze mid-MAC, dwell=3
    do_reset();
    cfg_layer_typ = CONV;
    cfg_mac_dwell = 4'd3;
    pu_matrix_rdy = 1'b1;
    bus.rdata_rdy = 1'b1;
    bus.wback_start = 1'b1;
    step();
    clr_bus();
    mac_cycles = 0;
    if (pu_enb != 0) mac_cycles++;
    step();
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_pu", 64'(pu_enb), 64'h1FF);
      chk("frz_rdy", 64'(bus.comps_rdy), 0);
    end
    enb = 1'b1;
    for (int i = 0; i < 6 && pu_enb != 0; i++) begin
      mac_cycles++;
      step();
    end
    chk("frz_mac_cycles", 64'(mac_cycles), 3);
    chk("frz_acc", 64'(acc_inter_sum_write), 1);
    step();
    chk("frz_rdy_end", 64'(bus.comps_rdy), 1);
`ifdef COMPS_PERF_CNT_EN
    chk("perf_busy", 64'(perf_busy_cnt), 4);
    step();
    step();
    chk("perf_stall", 64'(perf_stall_cnt), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
